// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stage enables, flushes and load-use bubbles,
// plus data-memory wait tracking with a timeout fault and stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT     = 255,
  parameter int INIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rf_valid,
  input  logic        rf_uses_Rn,
  input  logic        rf_uses_Rm,
  input  logic [4:0]  rf_Rn,
  input  logic [4:0]  rf_Rm,
  input  logic        ex_valid,
  input  logic        ex_MemRead,
  input  logic        ex_RegWrite,
  input  logic [4:0]  ex_Rd,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_write,
  output logic        rf_write,
  output logic        ex_write,
  output logic        mem_write,
  output logic        ex_bubble,
  output logic        if_flush,
  output logic        rf_flush,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  // state    | meaning
  // INIT     | post-reset bubbles, pipeline squashed, PC held
  // RUN      | normal issue; branch flush / load-use bubble / memory stall
  // MEM_WAIT | whole pipe frozen until data memory is ready
  // FAULT    | memory never answered; frozen until reset
  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_t          state_q, state_nxt;
  logic [IW-1:0]   init_cnt, init_nxt;
  logic [WW-1:0]   wait_cnt, wait_nxt;
  logic            timeout_set;
  logic            flush_inc;
  logic            load_use;
  logic            mem_stall;

  // X31 reads as zero, so a load targeting it never creates a dependency
  assign load_use = rf_valid & ex_valid & ex_MemRead & ex_RegWrite & (ex_Rd != 5'd31) &
                    ((rf_uses_Rn & (rf_Rn == ex_Rd)) | (rf_uses_Rm & (rf_Rm == ex_Rd)));
  assign mem_stall = mem_req & ~mem_ready;

  always_comb begin
    pc_write    = 1'b0;
    if_write    = 1'b0;
    rf_write    = 1'b0;
    ex_write    = 1'b0;
    mem_write   = 1'b0;
    ex_bubble   = 1'b0;
    if_flush    = 1'b0;
    rf_flush    = 1'b0;
    state_nxt   = state_q;
    init_nxt    = init_cnt;
    wait_nxt    = wait_cnt;
    timeout_set = 1'b0;
    flush_inc   = 1'b0;

    if (state_q == S_INIT) begin
      {if_write, rf_write, ex_write, mem_write} = 4'b1111;
      {ex_bubble, if_flush, rf_flush}           = 3'b111;
      if (init_cnt == IW'(INIT_CYCLES - 1)) begin
        state_nxt = S_RUN;
        init_nxt  = '0;
      end else begin
        init_nxt = init_cnt + IW'(1);
      end
    end else if (state_q == S_RUN || (state_q == S_MEM_WAIT && mem_ready)) begin
      // a MEM_WAIT release cycle behaves exactly like a RUN cycle
      wait_nxt  = '0;
      state_nxt = S_RUN;
      if (mem_stall) begin
        state_nxt = S_MEM_WAIT;
        wait_nxt  = WW'(1);
      end else if (ex_br_taken) begin
        {pc_write, if_write, rf_write, ex_write, mem_write} = 5'b11111;
        {if_flush, rf_flush} = 2'b11;
        flush_inc = 1'b1;
      end else if (load_use) begin
        {rf_write, ex_write, mem_write} = 3'b111;
        ex_bubble = 1'b1;
      end else begin
        {pc_write, if_write, rf_write, ex_write, mem_write} = 5'b11111;
      end
    end else if (state_q == S_MEM_WAIT) begin
      if (wait_cnt >= WW'(TIMEOUT - 1)) begin
        state_nxt   = S_FAULT;
        timeout_set = 1'b1;
      end else begin
        wait_nxt = wait_cnt + WW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      init_cnt     <= '0;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state_q     <= state_nxt;
      init_cnt    <= init_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= mem_timeout | timeout_set;
      if ((state_q == S_RUN || state_q == S_MEM_WAIT) && !pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_inc && flush_count != '1)
        flush_count <= flush_count + 16'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: init bubbles, load-use, XZR, branch
// priority, memory wait, timeout fault and asynchronous reset.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        rf_valid, rf_uses_Rn, rf_uses_Rm;
  logic [4:0]  rf_Rn, rf_Rm;
  logic        ex_valid, ex_MemRead, ex_RegWrite;
  logic [4:0]  ex_Rd;
  logic        ex_br_taken, mem_req, mem_ready;
  logic        pc_write, if_write, rf_write, ex_write, mem_write;
  logic        ex_bubble, if_flush, rf_flush;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  logic [7:0]  en;

  int checks = 0;
  int errors = 0;

  // enable vector: {pc,if,rf,ex,mem,bubble,if_flush,rf_flush}
  localparam logic [7:0] EN_INIT  = 8'b0111_1111;
  localparam logic [7:0] EN_RUN   = 8'b1111_1000;
  localparam logic [7:0] EN_FROZE = 8'b0000_0000;
  localparam logic [7:0] EN_BR    = 8'b1111_1011;
  localparam logic [7:0] EN_LU    = 8'b0011_1100;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rf_valid(rf_valid), .rf_uses_Rn(rf_uses_Rn), .rf_uses_Rm(rf_uses_Rm),
    .rf_Rn(rf_Rn), .rf_Rm(rf_Rm),
    .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite),
    .ex_Rd(ex_Rd), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_write(if_write), .rf_write(rf_write),
    .ex_write(ex_write), .mem_write(mem_write),
    .ex_bubble(ex_bubble), .if_flush(if_flush), .rf_flush(rf_flush),
    .state(state), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign en = {pc_write, if_write, rf_write, ex_write, mem_write, ex_bubble, if_flush, rf_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rf_valid = 0; rf_uses_Rn = 0; rf_uses_Rm = 0; rf_Rn = 0; rf_Rm = 0;
    ex_valid = 0; ex_MemRead = 0; ex_RegWrite = 0; ex_Rd = 0;
    ex_br_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_load_rn(input logic [4:0] rd, input logic [4:0] rn);
    rf_valid = 1; rf_uses_Rn = 1; rf_Rn = rn;
    ex_valid = 1; ex_MemRead = 1; ex_RegWrite = 1; ex_Rd = rd;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    #3;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_en", 32'(en), 32'(EN_INIT));
    chk("reset_stall", stall_cycles, 32'd0);
    chk("reset_flush", 32'(flush_count), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);

    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("init0_en", 32'(en), 32'(EN_INIT));
    tick();
    chk("init1_state", 32'(state), 32'd0);
    chk("init1_en", 32'(en), 32'(EN_INIT));
    tick();
    chk("run_state", 32'(state), 32'd1);
    chk("run_en", 32'(en), 32'(EN_RUN));
    chk("run_stall0", stall_cycles, 32'd0);

    // LDUR X3 in EX, ADD reads X3 via Rn
    set_load_rn(5'd3, 5'd3);
    #1;
    chk("lu_rn_en", 32'(en), 32'(EN_LU));
    tick();
    chk("lu_stall1", stall_cycles, 32'd1);
    ex_valid = 0;
    #1;
    chk("lu_after_en", 32'(en), 32'(EN_RUN));

    // load-use through Rm only; Rm not used; no RegWrite; XZR
    clear_inputs();
    ex_valid = 1; ex_MemRead = 1; ex_RegWrite = 1; ex_Rd = 5'd7;
    rf_valid = 1; rf_uses_Rm = 1; rf_Rm = 5'd7;
    #1;
    chk("lu_rm_en", 32'(en), 32'(EN_LU));
    rf_uses_Rm = 0;
    #1;
    chk("rm_unused_en", 32'(en), 32'(EN_RUN));
    rf_uses_Rm = 1; ex_RegWrite = 0;
    #1;
    chk("no_regwrite_en", 32'(en), 32'(EN_RUN));
    ex_RegWrite = 1; ex_Rd = 5'd31; rf_Rm = 5'd31;
    #1;
    chk("xzr_en", 32'(en), 32'(EN_RUN));
    clear_inputs();
    mem_ready = 0; mem_req = 0;
    #1;
    chk("no_req_en", 32'(en), 32'(EN_RUN));

    // taken branch wins over a simultaneous load-use
    set_load_rn(5'd5, 5'd5);
    ex_br_taken = 1;
    #1;
    chk("br_lu_en", 32'(en), 32'(EN_BR));
    tick();
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_stall", stall_cycles, 32'd1);
    clear_inputs();

    // memory stall: 1 RUN cycle + 3 MEM_WAIT cycles with ready low
    mem_req = 1; mem_ready = 0;
    #1;
    chk("ms_run_en", 32'(en), 32'(EN_FROZE));
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("mw_state", 32'(state), 32'd2);
      chk("mw_en", 32'(en), 32'(EN_FROZE));
      tick();
    end
    chk("mw_stall", stall_cycles, 32'd5);
    mem_ready = 1; ex_br_taken = 1;
    #1;
    chk("mw_release_en", 32'(en), 32'(EN_BR));
    tick();
    chk("mw_back_run", 32'(state), 32'd1);
    chk("mw_br_flush_cnt", 32'(flush_count), 32'd2);
    chk("mw_stall_after", stall_cycles, 32'd5);
    clear_inputs();

    // timeout: 254 stalled cycles stay in MEM_WAIT, the 255th faults
    mem_req = 1; mem_ready = 0;
    tick();
    repeat (253) tick();
    chk("to_pre_state", 32'(state), 32'd2);
    chk("to_pre_flag", 32'(mem_timeout), 32'd0);
    tick();
    chk("to_state", 32'(state), 32'd3);
    chk("to_flag", 32'(mem_timeout), 32'd1);
    chk("to_stall", stall_cycles, 32'd260);
    mem_req = 0; mem_ready = 1;
    #1;
    chk("fault_en", 32'(en), 32'(EN_FROZE));
    tick();
    chk("fault_hold", 32'(state), 32'd3);
    chk("fault_flag_hold", 32'(mem_timeout), 32'd1);
    chk("fault_stall_hold", stall_cycles, 32'd260);

    // asynchronous reset away from any clock edge
    #2;
    reset = 1;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_flag", 32'(mem_timeout), 32'd0);
    chk("ar_stall", stall_cycles, 32'd0);
    chk("ar_flush", 32'(flush_count), 32'd0);
    chk("ar_en", 32'(en), 32'(EN_INIT));
    clear_inputs();
    tick();
    reset = 0;
    tick();
    chk("ar_init_hold", 32'(state), 32'd0);
    tick();
    chk("ar_run", 32'(state), 32'd1);
    chk("ar_run_en", 32'(en), 32'(EN_RUN));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameters: TIMEOUT, default 255, maximum MEM_WAIT cycles before fault; INIT_CYCLES, default 2, post-reset bubble cycles.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 rf_valid, rf_uses_Rn, rf_uses_Rm  in  1 each  RF-stage instruction valid / reads Rn / reads Rm.
REQ-005 rf_Rn, rf_Rm  in  5 each  RF-stage source register ids.
REQ-006 ex_valid, ex_MemRead, ex_RegWrite  in  1 each  EX-stage instruction valid / is load / writes register.
REQ-007 ex_Rd  in  5  EX-stage destination id.
REQ-008 ex_br_taken  in  1  branch resolved taken in EX this cycle.
REQ-009 mem_req, mem_ready  in  1 each  MEM-stage access pending / data memory done.
REQ-010 pc_write, if_write, rf_write, ex_write, mem_write  out  1 each  stage register enables.
REQ-011 ex_bubble, if_flush, rf_flush  out  1 each  insert NOP into RF/EX register / squash IF/RF register / squash RF/EX register.
REQ-012 state  out  2  FSM state: INIT=0, RUN=1, MEM_WAIT=2, FAULT=3.
REQ-013 mem_timeout  out  1  sticky fault flag.
REQ-014 stall_cycles  out  32  saturating count of cycles with pc_write=0 in RUN/MEM_WAIT.
REQ-015 flush_count  out  16  saturating count of taken-branch flushes.

Function
REQ-016 Enable/flush outputs SHALL be combinational from state and current inputs; state, counters, mem_timeout SHALL be registered.
REQ-017 load_use SHALL be: rf_valid & ex_valid & ex_MemRead & ex_RegWrite & ex_Rd!=31 & ((rf_uses_Rn & rf_Rn==ex_Rd) | (rf_uses_Rm & rf_Rm==ex_Rd)).
REQ-018 mem_stall SHALL be: mem_req & ~mem_ready.
REQ-019 INIT: all *_write=1, ex_bubble=if_flush=rf_flush=1, pc_write=0; after INIT_CYCLES cycles -> RUN.
REQ-020 RUN, priority mem_stall > ex_br_taken > load_use > none.
REQ-021 RUN & mem_stall: all *_write=0, no flush/bubble; next state MEM_WAIT; wait counter loads 1.
REQ-022 RUN & ex_br_taken (no mem_stall): all *_write=1, if_flush=rf_flush=1; flush_count+1; load_use ignored this cycle.
REQ-023 RUN & load_use only: pc_write=if_write=0, ex_bubble=1, ex_write=mem_write=rf_write=1; exactly one bubble per load-use pair.
REQ-024 RUN & none: all *_write=1, no flush/bubble.
REQ-025 MEM_WAIT: all *_write=0 while mem_ready=0; wait counter increments each cycle.
REQ-026 MEM_WAIT & mem_ready: outputs per RUN rules for the same cycle's other inputs (branch/load_use evaluated), next state RUN.
REQ-027 MEM_WAIT with wait counter reaching TIMEOUT and mem_ready=0: next state FAULT, mem_timeout set.
REQ-028 FAULT: all *_write=0, no flush; hold until reset; mem_timeout stays 1.
REQ-029 Register id 31 (XZR) SHALL never cause load_use.
REQ-030 stall_cycles and flush_count SHALL saturate at all-ones, never wrap.

Reset
REQ-031 reset=1 SHALL immediately force state=INIT, INIT counter=0, wait counter=0, mem_timeout=0, stall_cycles=0, flush_count=0, regardless of clk.
REQ-032 Reset asserted mid-MEM_WAIT or in FAULT SHALL return to INIT with no residual stall.
REQ-033 During reset, outputs SHALL equal INIT values (pc_write=0, flushes=1).

Verification
REQ-034 Reset release -> exactly 2 cycles pc_write=0 with flushes, then state=RUN, pc_write=1.
REQ-035 LDUR X3 in EX, ADD reading X3 (Rn=3) in RF -> one cycle pc_write=if_write=0, ex_bubble=1; next cycle all enables 1; stall_cycles=1.
REQ-036 Load with ex_Rd=31 and RF reading Rm=31 -> no stall.
REQ-037 ex_br_taken=1 simultaneous with load_use -> if_flush=rf_flush=1, pc_write=1, no bubble, flush_count=1.
REQ-038 mem_req=1, mem_ready=0 for 3 cycles then 1 -> state MEM_WAIT for 3 cycles, all enables 0, then RUN; stall_cycles=4.
REQ-039 mem_ready held 0 for 255 cycles -> state=FAULT, mem_timeout=1; async reset mid-cycle -> state=INIT, counters 0.
